// File: rtl/seven_seg_reader.sv
// Seven-segment pattern reader: stability filter plus decode back to a digit code,
// reported once per distinct stable pattern over a valid/ready handshake.
module seven_seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seven,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [3:0] o_dec,
    output logic       o_blank,
    output logic       o_err
);
    typedef enum logic {TRACK, OFFER} state_t;

    localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    state_t     state;
    logic [6:0] trk;
    logic [6:0] rep;
    logic [7:0] cnt;
    logic       reported;
    logic       stable;
    logic       issue;
    logic [3:0] dec_d;
    logic       blank_d;
    logic       err_d;

    // Returns {dec[3:0], blank, err} for an active-low segment pattern.
    function automatic logic [5:0] decode(input logic [6:0] pat);
        logic [5:0] res;
        case (pat)
            7'b1000000: res = {4'd0, 2'b00};
            7'b1111001: res = {4'd1, 2'b00};
            7'b0100100: res = {4'd2, 2'b00};
            7'b0110000: res = {4'd3, 2'b00};
            7'b0011001: res = {4'd4, 2'b00};
            7'b0010010: res = {4'd5, 2'b00};
            7'b0000010: res = {4'd6, 2'b00};
            7'b1011000: res = {4'd7, 2'b00};
            7'b0000000: res = {4'd8, 2'b00};
            7'b0010000: res = {4'd9, 2'b00};
            PAT_BLANK:  res = {4'hF, 2'b10};
            default:    res = {4'hF, 2'b01};
        endcase
        return res;
    endfunction

    always_comb begin
        stable = (cnt == CNT_MAX);
        issue  = (state == TRACK) && stable && (!reported || (trk != rep));
        {dec_d, blank_d, err_d} = decode(trk);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            trk      <= PAT_BLANK;
            cnt      <= 8'd0;
            rep      <= PAT_BLANK;
            reported <= 1'b0;
            state    <= TRACK;
            o_valid  <= 1'b0;
            o_dec    <= 4'd0;
            o_blank  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            // Tracking runs every cycle regardless of the handshake.
            trk <= i_seven;
            if (i_seven == trk)
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
            else
                cnt <= 8'd0;

            case (state)
                TRACK: begin
                    if (issue) begin
                        state    <= OFFER;
                        o_valid  <= 1'b1;
                        rep      <= trk;
                        reported <= 1'b1;
                        o_dec    <= dec_d;
                        o_blank  <= blank_d;
                        o_err    <= err_d;
                    end
                end
                OFFER: begin
                    // Report fields stay frozen until the consumer accepts.
                    if (i_ready) begin
                        state   <= TRACK;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= TRACK;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: default-parameter instance driven through the
// scenario tasks, plus a STABLE_CYCLES=1 instance for the digit sweep.
module tb_seven_seg_reader;
    logic       clk;
    logic       rst;
    logic [6:0] seven;
    logic       ready;
    logic       valid;
    logic [3:0] dec;
    logic       blank;
    logic       err;

    logic [6:0] seven1;
    logic       ready1;
    logic       valid1;
    logic [3:0] dec1;
    logic       blank1;
    logic       err1;

    int n_assert  = 0;
    int n_fail    = 0;
    int n_reports = 0;

    logic [5:0] exp_q[$];

    logic [6:0] pats[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};

    seven_seg_reader #(.STABLE_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_seven(seven), .i_ready(ready),
        .o_valid(valid), .o_dec(dec), .o_blank(blank), .o_err(err)
    );

    seven_seg_reader #(.STABLE_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_seven(seven1), .i_ready(ready1),
        .o_valid(valid1), .o_dec(dec1), .o_blank(blank1), .o_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted report is matched against the oldest expectation.
    always @(negedge clk) begin
        if (valid && ready) begin
            logic [5:0] e;
            n_reports++;
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_report: got dec=%h blank=%b err=%b, expected none",
                         dec, blank, err);
            end else begin
                e = exp_q.pop_front();
                if ({dec, blank, err} !== e) begin
                    n_fail++;
                    $display("FAIL report: got dec=%h blank=%b err=%b, expected dec=%h blank=%b err=%b",
                             dec, blank, err, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst    = 1'b0;
        seven  = 7'b1000000;
        ready  = 1'b1;
        seven1 = 7'b1111111;
        ready1 = 1'b1;
        tick(2);
        n_assert++;
        if ({valid, dec, blank, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b dec=%h blank=%b err=%b, expected all 0",
                     valid, dec, blank, err);
        end
    endtask

    task automatic test_basic;
        int base;
        exp_q.push_back({4'd0, 2'b00});
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_assert++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_early_valid edge%0d: got %b, expected 0", k, valid);
            end
        end
        @(negedge clk);
        n_assert++;
        if (valid !== 1'b1 || dec !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_edge4: got valid=%b dec=%h, expected valid=1 dec=0", valid, dec);
        end
        @(negedge clk);
        n_assert++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: got valid=%b, expected 0", valid);
        end
        base = n_reports;
        tick(8);
        n_assert++;
        if (n_reports != base) begin
            n_fail++;
            $display("FAIL basic_repeat: got %0d extra reports, expected 0", n_reports - base);
        end
    endtask

    task automatic test_glitch;
        int base;
        base  = n_reports;
        seven = 7'b0100100;
        tick(2);
        seven = 7'b1000000;
        tick(10);
        n_assert++;
        if (n_reports != base) begin
            n_fail++;
            $display("FAIL glitch_reported: got %0d reports, expected 0", n_reports - base);
        end
        seven = 7'b0100100;
        exp_q.push_back({4'd2, 2'b00});
        tick(6);
        n_assert++;
        if (n_reports != base + 1) begin
            n_fail++;
            $display("FAIL glitch_digit2: got %0d reports, expected 1", n_reports - base);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        ready = 1'b0;
        seven = 7'b0110000;
        exp_q.push_back({4'd3, 2'b00});
        tick(5);
        bad = 0;
        for (int c = 5; c < 15; c++) begin
            if (c == 6) begin
                seven = 7'b0011001;
                exp_q.push_back({4'd4, 2'b00});
            end
            if (valid !== 1'b1 || dec !== 4'd3) bad++;
            @(negedge clk);
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d cycles without valid=1 dec=3, expected 0", bad);
        end
        ready = 1'b1;
        @(negedge clk);
        n_assert++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: got valid=%b, expected 0", valid);
        end
        @(negedge clk);
        n_assert++;
        if (valid !== 1'b1 || dec !== 4'd4) begin
            n_fail++;
            $display("FAIL bp_next: got valid=%b dec=%h, expected valid=1 dec=4", valid, dec);
        end
        tick(2);
    endtask

    task automatic test_err_blank;
        int base;
        base  = n_reports;
        seven = 7'b1111110;
        exp_q.push_back({4'hF, 2'b01});
        tick(6);
        seven = 7'b1111111;
        exp_q.push_back({4'hF, 2'b10});
        tick(6);
        n_assert++;
        if (n_reports != base + 2) begin
            n_fail++;
            $display("FAIL err_blank_count: got %0d reports, expected 2", n_reports - base);
        end
    endtask

    task automatic test_reset_mid_offer;
        ready = 1'b0;
        seven = 7'b0000010;
        exp_q.push_back({4'd6, 2'b00});
        tick(5);
        n_assert++;
        if (valid !== 1'b1 || dec !== 4'd6) begin
            n_fail++;
            $display("FAIL rst_pre_offer: got valid=%b dec=%h, expected valid=1 dec=6", valid, dec);
        end
        #2 rst = 1'b0;
        #1;
        n_assert++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_drop: got valid=%b, expected 0", valid);
        end
        @(negedge clk);
        rst   = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_assert++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_early_valid edge%0d: got %b, expected 0", k, valid);
            end
        end
        @(negedge clk);
        n_assert++;
        if (valid !== 1'b1 || dec !== 4'd6) begin
            n_fail++;
            $display("FAIL rst_rereport: got valid=%b dec=%h, expected valid=1 dec=6", valid, dec);
        end
        tick(2);
    endtask

    task automatic test_sweep;
        for (int d = 0; d < 10; d++) begin
            seven1 = pats[d];
            @(negedge clk);
            n_assert++;
            if (valid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_early digit%0d: got valid=%b, expected 0", d, valid1);
            end
            @(negedge clk);
            n_assert++;
            if (valid1 !== 1'b1 || dec1 !== 4'(d) || blank1 !== 1'b0 || err1 !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep digit%0d: got valid=%b dec=%h blank=%b err=%b, expected valid=1 dec=%0d blank=0 err=0",
                         d, valid1, dec1, blank1, err1, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_backpressure();
        test_err_blank();
        test_reset_mid_offer();
        test_sweep();
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_reports: got %0d unreported, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Reads a 7-bit active-low seven-segment pattern bus, filters it for stability, and converts it back to a digit code with a valid/ready output handshake. It is the inverse of the display segment decoder. It sits wherever a segment bus must be interpreted as a number: display loop-back checking, or front-panel patterns re-entering the game logic. Each distinct stable pattern is reported exactly once.

## Interface
- STABLE_CYCLES, 4: consecutive cycles a pattern must persist before it is reported; legal range 1..255.
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_seven  input  7  segment pattern, active-low (0 = lit); bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle.
- i_ready  input  1  consumer accepts the current report.
- o_valid  output  1  report pending.
- o_dec  output  4  decoded digit 0..9; 4'hF for blank or error.
- o_blank  output  1  reported pattern is all-dark (7'b1111111).
- o_err  output  1  reported pattern is not a legal digit and not blank.

## Operation
- Legal patterns:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1011000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
  - Any other value is an error.
- Tracking runs every cycle, independent of the handshake:
  - The block registers the pattern (trk = i_seven).
  - cnt is 8 bits. If i_seven == trk, cnt saturating-increments up to STABLE_CYCLES-1; otherwise cnt clears to 0.
- The stable condition is cnt == STABLE_CYCLES-1.
- A report is issued when all of the following hold: stable, o_valid = 0, and (no report since reset, or trk != rep), where rep is the last reported pattern.
- On issue: o_valid = 1, and rep, o_dec, o_blank and o_err load from the decode of trk.
- Output hold: while o_valid = 1 and i_ready = 0, o_dec, o_blank and o_err do not change, whatever i_seven does.
- Accept: when o_valid && i_ready, o_valid clears on the next edge. The next report can be issued at the earliest one cycle later.
- Intermediate patterns that come and go while a report is held are never reported. Only the pattern stable at the time of issue counts.
- State machine:
  - TRACK (o_valid = 0) → OFFER on report issue.
  - OFFER (o_valid = 1) → TRACK on accept.
- Reset values:
  - trk = 1111111, cnt = 0, rep = 1111111, reported flag = 0, state TRACK.
  - o_valid = 0, o_dec = 0, o_blank = 0, o_err = 0.

## Timing
- Latency: a new pattern present before edge 0 sets trk at edge 0 with cnt = 0. o_valid rises after edge STABLE_CYCLES (4 edges with the default).
- With STABLE_CYCLES = 1, o_valid rises after edge 1.
- If the input returns to rep before going stable, nothing is reported.
- If a new pattern was already stable during OFFER, it is issued on the edge after the accepting edge.
- Simultaneous accept and input change: the accept takes effect; tracking restarts from cnt = 0 per the normal rule.
- Reset asserted mid-OFFER: o_valid drops immediately (asynchronous). After release, the current input is reported again once stable, even if it equals the pre-reset report.
- Outputs are registered with no combinational path from i_seven or i_ready to any output.

## Test plan
- Basic digit:
  - Stimulus: reset; i_seven = 1000000 held; i_ready = 1.
  - Response: o_valid is high for exactly 1 cycle after edge 4, with o_dec = 0, o_blank = 0, o_err = 0; no further reports while the input is held.
- Glitch rejection:
  - Stimulus: after the digit 0 report, apply 0100100 for 2 cycles, then 1000000.
  - Response: no report.
  - Stimulus: then 0100100 held.
  - Response: one report with o_dec = 2.
- Backpressure:
  - Stimulus: i_ready = 0; 0110000 held 6 cycles; then 0011001 held; i_ready = 1 at cycle 15.
  - Response: o_dec = 3 stays held until the accept; on the next cycle a report with o_dec = 4.
- Error and blank:
  - Stimulus: 1111110 held.
  - Response: o_err = 1, o_dec = F.
  - Stimulus: then 1111111 held.
  - Response: o_blank = 1, o_err = 0, o_dec = F.
- Reset mid-offer:
  - Stimulus: i_ready = 0 with 0000010 reported; assert i_rst mid-cycle.
  - Response: o_valid = 0 at once; after release, 0000010 is reported again 4 edges later with o_dec = 6.
- Sweep and parameter:
  - Stimulus: all 10 digits with STABLE_CYCLES = 1 and i_ready = 1.
  - Response: each digit is reported 1 edge after it is applied, with the correct o_dec.
